// File: rtl/rr_grant_sequencer_8_if.sv
// rr_grant_sequencer_8_if: request/grant bus between requesters and the round-robin arbiter
interface rr_grant_sequencer_8_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       preempt;
    modport master (output en, req, input grant, grant_idx, grant_valid, preempt);
    modport slave  (input en, req, output grant, grant_idx, grant_valid, preempt);
endinterface

// File: rtl/rr_grant_sequencer_8.sv
// rr_grant_sequencer_8: 8-way round-robin arbiter with registered one-hot grant and hold-limit preemption
module rr_grant_sequencer_8 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    rr_grant_sequencer_8_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [HOLD_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? '1 : HOLD_W'(MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d, ptr_q, ptr_d, nxt;
    logic              valid_q, valid_d, pre_q, pre_d;
    logic [7:0]        grant_q, grant_d, owner_oh, others;
    logic [HOLD_W-1:0] hold_q, hold_d;

    // first set bit of v scanning start, start+1, ... with 3-bit wrap
    function automatic logic [2:0] pick(input logic [2:0] start, input logic [7:0] v);
        logic [2:0] r, k;
        r = start;
        for (int i = 7; i >= 0; i--) begin
            k = start + 3'(i);
            if (v[k]) r = k;
        end
        return r;
    endfunction

    always_comb begin
        owner_oh = 8'h01 << idx_q;
        others   = bus.req & ~owner_oh;
        nxt      = idx_q + 3'd1;
        state_d  = state_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        pre_d    = 1'b0;
        if (state_q == IDLE) begin
            if (bus.en && |bus.req) begin
                idx_d   = pick(ptr_q, bus.req);
                valid_d = 1'b1;
                hold_d  = '0;
                state_d = BUSY;
            end
        end else if (!bus.req[idx_q]) begin
            ptr_d  = nxt;
            hold_d = '0;
            if (bus.en && |others) begin
                idx_d = pick(nxt, others);
            end else begin
                idx_d   = 3'd0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        end else if (MAX_HOLD != 0 && hold_q == HOLD_SAT && bus.en && |others) begin
            idx_d  = pick(nxt, others);
            ptr_d  = nxt;
            hold_d = '0;
            pre_d  = 1'b1;
        end else if (hold_q != HOLD_SAT) begin
            hold_d = hold_q + 1'b1;
        end
        grant_d = valid_d ? (8'h01 << idx_d) : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            grant_q <= 8'h00;
            pre_q   <= 1'b0;
            ptr_q   <= 3'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
            pre_q   <= pre_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
    assign bus.preempt     = pre_q;
endmodule

// File: tb/tb_rr_grant_sequencer_8.sv
// tb_rr_grant_sequencer_8: randomized and directed checks of the arbiter against an owner/ptr/held-cycles model
module tb_rr_grant_sequencer_8;
    localparam int MH = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    rr_grant_sequencer_8_if bus();
    rr_grant_sequencer_8 #(.MAX_HOLD(MH), .HOLD_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    int total = 0, passed = 0;
    int owner = -1, held = 0, ptr = 0;
    bit pre = 0;
    int seq[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int pick(input int start, input logic [7:0] v);
        for (int k = 0; k < 8; k++) if (v[(start + k) % 8]) return (start + k) % 8;
        return -1;
    endfunction

    function automatic void model_reset();
        owner = -1; held = 0; ptr = 0; pre = 0;
    endfunction

    // what the arbiter must do at one rising edge, given the inputs present before it
    function automatic void model_edge(input logic e, input logic [7:0] r);
        logic [7:0] oth;
        pre = 0;
        if (!rst_n) begin model_reset(); return; end
        if (owner < 0) begin
            if (e && r != 0) begin owner = pick(ptr, r); held = 1; end
            return;
        end
        oth = r & ~(8'h01 << owner);
        if (!r[owner]) begin
            ptr = (owner + 1) % 8;
            if (e && oth != 0) begin owner = pick(ptr, oth); held = 1; end
            else owner = -1;
        end else if (MH > 0 && held >= MH && e && oth != 0) begin
            ptr = (owner + 1) % 8;
            owner = pick(ptr, oth);
            held = 1;
            pre = 1;
        end else held++;
    endfunction

    task automatic compare();
        chk("grant_valid", int'(bus.grant_valid), owner >= 0 ? 1 : 0);
        chk("grant_idx", int'(bus.grant_idx), owner >= 0 ? owner : 0);
        chk("grant", int'(bus.grant), owner >= 0 ? (1 << owner) : 0);
        chk("preempt", int'(bus.preempt), int'(pre));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(bus.en, bus.req);
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.en = 1'b1;
        bus.req = 8'hFF;
        #1;
        compare();
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("reset_first_grant", int'(bus.grant), 8'h01);

        // rotation: each owner drops its request for one cycle after two owned cycles
        do_reset();
        bus.req = 8'h89;
        for (int c = 0; c < 12; c++) begin
            step();
            if (seq.size() == 0 || seq[$] != int'(bus.grant)) seq.push_back(int'(bus.grant));
            bus.req = 8'h89;
            if (owner >= 0 && held == 2) bus.req[owner] = 1'b0;
        end
        chk("rot_len", seq.size() >= 4 ? 1 : 0, 1);
        if (seq.size() >= 4) begin
            chk("rot0", seq[0], 8'h01);
            chk("rot1", seq[1], 8'h08);
            chk("rot2", seq[2], 8'h80);
            chk("rot3", seq[3], 8'h01);
        end

        // preemption after MH cycles with a competitor waiting
        do_reset();
        bus.req = 8'h06;
        for (int c = 0; c < 9; c++) begin
            step();
            chk("pre_seq", int'(bus.grant), (c < 4 || c == 8) ? 8'h02 : 8'h04);
            chk("pre_pulse", int'(bus.preempt), (c == 4 || c == 8) ? 1 : 0);
        end

        // lone owner never preempted
        do_reset();
        bus.req = 8'h20;
        for (int c = 0; c < 50; c++) begin
            step();
            chk("lone_pre", int'(bus.preempt), 0);
        end
        chk("lone_grant", int'(bus.grant), 8'h20);

        // en gating
        do_reset();
        bus.en = 1'b0;
        bus.req = 8'h10;
        for (int c = 0; c < 3; c++) step();
        chk("en0_valid", int'(bus.grant_valid), 0);
        bus.en = 1'b1;
        step();
        chk("en1_grant", int'(bus.grant), 8'h10);
        bus.en = 1'b0;
        bus.req = 8'h11;
        for (int c = 0; c < 10; c++) step();
        chk("en0_hold", int'(bus.grant), 8'h10);
        bus.req = 8'h01;
        step();
        chk("en0_release", int'(bus.grant_valid), 0);
        bus.en = 1'b1;

        // async reset while 8'h40 owns
        do_reset();
        bus.req = 8'h40;
        step();
        chk("pre_async", int'(bus.grant), 8'h40);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_grant", int'(bus.grant), 0);
        chk("async_valid", int'(bus.grant_valid), 0);
        bus.req = 8'hFF;
        step();
        rst_n = 1'b1;
        step();
        chk("restart_ptr0", int'(bus.grant), 8'h01);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req = bus.req ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            bus.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            step();
            chk("onehot", $countones(bus.grant) <= 1 ? 1 : 0, 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
